// File: rtl/spi_arbiter_if.sv
// ============================================================================
// Module  : spi_arbiter_if
// Brief   : Request/grant and SPI-master handshake bundle for spi_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface spi_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [12*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic [N_REQ-1:0]    err;
    logic                newd;
    logic [11:0]         din;
    logic                cs;
    logic                busy;

    modport master (
        output req, req_data, cs,
        input  gnt, done, err, newd, din, busy
    );

    modport slave (
        input  req, req_data, cs,
        output gnt, done, err, newd, din, busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_arbiter.sv
// ============================================================================
// Module  : spi_arbiter
// Brief   : Round-robin arbiter handing one of N_REQ words to an SPI master.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic          clk,
    input  logic          rst,
    spi_arbiter_if.slave  bus
);

    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_launch = 2'd1;
    localparam logic [1:0] c_xfer   = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;

    logic               cs_meta_q, cs_s_q;
    logic [1:0]         state_q, state_d;
    logic [c_ptr_w-1:0] ptr_q, ptr_d;
    logic [c_ptr_w-1:0] winner_q, winner_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [11:0]        din_q, din_d;
    logic [N_REQ-1:0]   err_q, err_d;

    logic               w_found;
    logic [c_ptr_w-1:0] w_pick;
    logic [c_ptr_w:0]   w_sum;
    logic [11:0]        w_word;
    logic [N_REQ-1:0]   w_win_oh;
    logic [c_ptr_w-1:0] w_next_ptr;
    logic               w_timeout;

    // cs is driven from the SPI master's domain; idle level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_meta_q <= 1'b1;
            cs_s_q    <= 1'b1;
        end else begin
            cs_meta_q <= bus.cs;
            cs_s_q    <= cs_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= c_idle;
            ptr_q    <= '0;
            winner_q <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            err_q    <= err_d;
        end
    end

    // Search ptr, ptr+1, ... with wrap; the first requester found wins
    always_comb begin
        w_found = 1'b0;
        w_pick  = ptr_q;
        w_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, ptr_q} + (c_ptr_w+1)'(i);
            if (w_sum >= (c_ptr_w+1)'(N_REQ)) begin
                w_sum = w_sum - (c_ptr_w+1)'(N_REQ);
            end
            if (!w_found && bus.req[w_sum[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_ptr_w-1:0];
            end
        end
    end

    always_comb begin
        w_word   = '0;
        w_win_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_pick == c_ptr_w'(j)) begin
                w_word = bus.req_data[12*j +: 12];
            end
            w_win_oh[j] = (winner_q == c_ptr_w'(j));
        end
    end

    assign w_next_ptr = (winner_q == c_ptr_w'(N_REQ - 1)) ? '0 : winner_q + c_ptr_w'(1);
    assign w_timeout  = cs_s_q && (cnt_q == c_cnt_w'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        err_d    = '0;
        case (state_q)
            c_idle: begin
                cnt_d = '0;
                if (w_found) begin
                    winner_d = w_pick;
                    din_d    = w_word;
                    state_d  = c_launch;
                end
            end
            c_launch: begin
                cnt_d = cnt_q + c_cnt_w'(1);
                if (!cs_s_q) begin
                    state_d = c_xfer;
                end else if (w_timeout) begin
                    err_d   = w_win_oh;
                    ptr_d   = w_next_ptr;
                    state_d = c_idle;
                end
            end
            c_xfer: begin
                if (cs_s_q) begin
                    state_d = c_done;
                end
            end
            c_done: begin
                ptr_d   = w_next_ptr;
                state_d = c_idle;
            end
            default: state_d = c_idle;
        endcase
    end

    // err is registered so it lands in the IDLE cycle after the abort, never beside done
    always_comb begin
        bus.gnt  = '0;
        bus.done = '0;
        bus.newd = 1'b0;
        bus.busy = 1'b1;
        case (state_q)
            c_idle:   bus.busy = 1'b0;
            c_launch: begin
                bus.gnt  = w_win_oh;
                bus.newd = 1'b1;
            end
            c_xfer:   bus.gnt = w_win_oh;
            c_done: begin
                bus.gnt  = w_win_oh;
                bus.done = w_win_oh;
            end
            default:  bus.busy = 1'b0;
        endcase
    end

    assign bus.err = err_q;
    assign bus.din = din_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
// ============================================================================
// Module  : tb_spi_arbiter
// Brief   : Directed self-checking bench for spi_arbiter (N_REQ=4, TIMEOUT_CYC=256).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    spi_arbiter_if #(.N_REQ(4)) bus ();

    spi_arbiter #(
        .N_REQ       (4),
        .TIMEOUT_CYC (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_word(input int i, input logic [11:0] w);
        bus.req_data[12*i +: 12] = w;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Entered just after the grant edge; leaves the DUT in IDLE after done
    task automatic run_xfer(input logic [3:0] g, input logic [11:0] w, input bit drop, input bit keep);
        chk("gnt_at_grant", gnt_w(), g);
        chk("din_at_grant", bus.din, w);
        chk("newd_launch", bus.newd, 1);
        chk("busy_launch", bus.busy, 1);
        bus.cs = 1'b0;
        tick();
        tick();
        chk("newd_cs_syncing", bus.newd, 1);
        tick();
        chk("newd_xfer", bus.newd, 0);
        chk("gnt_xfer", gnt_w(), g);
        if (drop) begin
            bus.req      = bus.req & ~g;
            bus.req_data = ~bus.req_data;
        end
        tick();
        tick();
        chk("din_hold_xfer", bus.din, w);
        bus.cs = 1'b1;
        tick();
        tick();
        chk("done_early", bus.done, 0);
        tick();
        chk("done_pulse", bus.done, g);
        chk("err_with_done", bus.err, 0);
        if (!keep) bus.req = bus.req & ~g;
        tick();
        chk("done_cleared", bus.done, 0);
        chk("gnt_cleared", gnt_w(), 0);
        chk("busy_idle", bus.busy, 0);
    endtask

    function automatic logic [3:0] gnt_w();
        return bus.gnt;
    endfunction

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.cs       = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_newd", bus.newd, 0);
        chk("rst_din", bus.din, 0);
        chk("rst_busy", bus.busy, 0);
        tick();
        tick();
        rst = 1'b1;

        // Single request from requester 1
        bus.req = 4'b0010;
        set_word(1, 12'hA5C);
        tick();
        run_xfer(4'b0010, 12'hA5C, 1'b0, 1'b0);

        // ptr is now 2; requesters 0 and 1 pending -> wrap selects 0, then 1
        bus.req = 4'b0011;
        set_word(0, 12'h5A5);
        set_word(1, 12'h0F0);
        tick();
        run_xfer(4'b0001, 12'h5A5, 1'b0, 1'b0);
        tick();
        run_xfer(4'b0010, 12'h0F0, 1'b0, 1'b0);

        // All four requesting continuously from reset: order 0,1,2,3,0
        rst          = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = {12'h444, 12'h333, 12'h222, 12'h111};
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_xfer(4'b0001, 12'h111, 1'b0, 1'b1);
        tick();
        run_xfer(4'b0010, 12'h222, 1'b0, 1'b1);
        tick();
        run_xfer(4'b0100, 12'h333, 1'b0, 1'b1);
        tick();
        run_xfer(4'b1000, 12'h444, 1'b0, 1'b1);
        tick();
        chk("rr_wrap_gnt", bus.gnt, 4'b0001);

        // cs never falls: abort 256 cycles after LAUNCH entry
        repeat (255) tick();
        chk("to_newd_before", bus.newd, 1);
        chk("to_err_before", bus.err, 0);
        chk("to_gnt_before", bus.gnt, 4'b0001);
        tick();
        chk("to_err_pulse", bus.err, 4'b0001);
        chk("to_newd_drop", bus.newd, 0);
        chk("to_gnt_clear", bus.gnt, 0);
        chk("to_done_none", bus.done, 0);
        tick();
        chk("to_err_clear", bus.err, 0);
        chk("to_next_gnt", bus.gnt, 4'b0010);
        chk("to_next_din", bus.din, 12'h222);

        // Requester 2 drops req and its data changes during XFER
        do_reset();
        bus.req      = 4'b0100;
        bus.req_data = '0;
        set_word(2, 12'h7E3);
        tick();
        run_xfer(4'b0100, 12'h7E3, 1'b1, 1'b0);

        // Reset asserted mid-XFER
        do_reset();
        bus.req      = 4'b0100;
        bus.req_data = '0;
        set_word(2, 12'h7E3);
        tick();
        chk("rx_gnt", bus.gnt, 4'b0100);
        bus.cs = 1'b0;
        tick();
        tick();
        tick();
        chk("rx_in_xfer", {bus.busy, bus.newd}, 2'b10);
        rst = 1'b0;
        #1;
        chk("rx_gnt_async", bus.gnt, 0);
        chk("rx_busy_async", bus.busy, 0);
        chk("rx_din_async", bus.din, 0);
        chk("rx_newd_async", bus.newd, 0);
        bus.req = 4'b1000;
        set_word(3, 12'hC3A);
        bus.cs = 1'b1;
        tick();
        chk("rx_done_none", bus.done, 0);
        chk("rx_err_none", bus.err, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rx_hold_after_release", bus.gnt, 0);
        tick();
        chk("rx_regrant", bus.gnt, 4'b1000);
        chk("rx_regrant_din", bus.din, 12'hC3A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 256: max clk cycles in LAUNCH waiting for cs low.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 req  input  N_REQ  per-requester transfer request, level, held until done or err.
REQ-006 req_data  input  12*N_REQ  packed words; requester i at [12i+11:12i].
REQ-007 gnt  output  N_REQ  one-hot grant, all-zero when idle.
REQ-008 done  output  N_REQ  one-cycle pulse on the granted bit at transfer completion.
REQ-009 err  output  N_REQ  one-cycle pulse on the granted bit at timeout abort.
REQ-010 newd  output  1  start strobe to the SPI master.
REQ-011 din  output  12  word to the SPI master.
REQ-012 cs  input  1  chip select from the SPI master, active-low, asynchronous to clk.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 cs SHALL pass through a 2-flop synchronizer (cs_s) before use; both flops reset to 1.
REQ-015 FSM states SHALL be IDLE, LAUNCH, XFER, DONE.
REQ-016 IDLE: if any req bit is high, select winner by round-robin, latch its req_data word into din, set gnt, go to LAUNCH next cycle.
REQ-017 Round-robin: winner = first index with req high, searching ptr, ptr+1, ... wrapping modulo N_REQ.
REQ-018 ptr SHALL reset to 0 and update to (winner+1) mod N_REQ on leaving DONE or on timeout.
REQ-019 LAUNCH: newd=1; on cs_s==0 go to XFER; timeout counter increments each cycle.
REQ-020 LAUNCH timeout: when counter reaches TIMEOUT_CYC-1 with cs_s still 1, pulse err[winner], clear gnt and newd, go to IDLE.
REQ-021 XFER: newd=0; on cs_s==1 go to DONE; no timeout in XFER.
REQ-022 DONE: pulse done[winner] for exactly one cycle, clear gnt, go to IDLE.
REQ-023 din SHALL stay constant from grant until return to IDLE; req_data changes after grant are ignored.
REQ-024 req dropping during LAUNCH/XFER SHALL NOT abort the transfer; done still pulses.
REQ-025 A requester still requesting after done SHALL NOT be re-granted ahead of other pending requesters.
REQ-026 Minimum IDLE dwell is one cycle between transfers (no back-to-back grant from DONE).
REQ-027 gnt, done, err SHALL each be one-hot or zero; done and err never high in the same cycle.
REQ-028 Timeout counter SHALL clear on every entry to LAUNCH.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, gnt=0, done=0, err=0, newd=0, din=0, busy=0, ptr=0, counter=0, sync flops=1.
REQ-030 Reset mid-transfer SHALL abandon it with no done or err pulse; after release, arbitration restarts from ptr=0.
REQ-031 Outputs SHALL remain at reset values until the first clk edge after rst returns high.

Verification
REQ-032 Single request: req=4'b0010, req_data[23:12]=12'hA5C -> gnt=0010 and din=A5C next cycle, newd high until cs_s low, done=0010 one cycle after cs_s returns high.
REQ-033 All four requesting continuously from reset -> grant order 0,1,2,3,0; each done precedes the next gnt.
REQ-034 cs held high by model, TIMEOUT_CYC=256 -> err[winner] pulses 256 cycles after LAUNCH entry, newd drops, next requester granted.
REQ-035 Requester 2 drops req during XFER -> transfer completes, done=0100, din unchanged throughout.
REQ-036 rst asserted during XFER -> all outputs at reset values immediately; no done; after release with req=1000, gnt=1000.
REQ-037 End-to-end with the SPI master: 12'h3F1 -> mosi shifts bits 1,0,0,0,1,1,1,1,1,1,0,0 (LSB first) while cs low, then done.
